muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Multi-cycle RV32M multiply/divide sequencer beside the single-cycle execute stage.
- Execute decodes an M-extension op and raises req_valid. This block holds the pipeline with stall, runs an iterative shift-add multiply or restoring divide, and returns the result with a one-cycle resp_valid.
- Keeps the single-cycle ALU free of a combinational 32x32 multiplier/divider.

Parameters:
- XLEN, 32, operand/result width; even, >= 8.
- CNTW, $clog2(XLEN)+1, iteration counter width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  M-op present in execute; held high and stable until the resp_valid cycle.
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  XLEN  rs1 value (busA).
- op_b  in  XLEN  rs2 value (busB).
- flush  in  1  cancel the in-flight op (trap/redirect).
- stall  out  1  freeze PC/regfile write; req_valid && !resp_valid.
- busy  out  1  state != IDLE.
- resp_valid  out  1  result valid this cycle; one-cycle pulse.
- result  out  XLEN  op result; holds its last value until the next DONE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter=0, internal regs=0, resp_valid=0, busy=0, result=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - req_valid=1 && !flush: latch funct3 and operand magnitudes; latch result sign.
  - Special case present: go DONE with the fixed result loaded.
  - Otherwise: go CALC with counter=0.
- CALC:
  - One iteration per cycle; counter increments.
  - After iteration XLEN-1 (counter==XLEN-1): go DONE.
  - Signs are applied on the DONE transition.
- DONE: resp_valid=1, stall=0; next edge goes to IDLE.
  - The CPU advances on that same edge, so the held request is not re-accepted.
- Latency:
  - Normal op: stall high for XLEN+1 cycles (IDLE accept cycle + XLEN CALC cycles); resp_valid in cycle XLEN+2 counting from the first req_valid cycle.
  - Special case: stall for 1 cycle; resp_valid in the 2nd cycle.
- Multiply:
  - Unsigned shift-add on magnitudes into a 2*XLEN product.
  - Product sign:
    - MULH: sign(a) xor sign(b).
    - MULHSU: sign(a).
    - MULHU/MUL: none. MUL takes the low half, which is sign-independent, so it is computed unsigned.
  - Negate the full 2*XLEN product if negative.
  - MUL returns the low XLEN bits; the others return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes (DIV/REM signed, DIVU/REMU unsigned).
  - Quotient negated if operand signs differ.
  - Remainder takes the dividend's sign.
- Special cases (no CALC):
  - op_b==0: DIV/DIVU return all-ones; REM/REMU return op_a.
  - Signed overflow (op_a = most-negative, op_b = -1): DIV returns op_a; REM returns 0.
- flush:
  - In any state, next state is IDLE, resp_valid is not asserted in the following cycle, and result is unchanged.
  - flush in the DONE cycle: resp_valid is still high in that cycle; the CPU owns the commit decision.
- req_valid dropping while in CALC: protocol violation. Not required to be handled; the bench asserts it never happens.
- Operands are registered at accept; later changes on op_a/op_b are ignored.
- Counter never wraps: it reaches XLEN-1 at most, then is reset in IDLE.

Decomposition:
- Shared package muldiv_pkg:
  - funct3 localparams (F3_MUL..F3_REMU).
  - state encoding (S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2).
  - helper constant for the most-negative XLEN value.
- Sub-module muldiv_dp:
  - Holds the 2*XLEN accumulator/remainder register, multiplicand/divisor register, one-iteration add/subtract and final sign fix-up.
  - Controlled by load/step/finish strobes from the FSM in muldiv_seq.

Test Plan:
- MUL, op_a=7, op_b=0xFFFFFFFD (-3) -> stall high for 33 cycles; resp_valid in cycle 34 with result=0xFFFFFFEB; resp_valid low next cycle.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU 100/7 -> 14; REMU -> 2.
- Special cases: DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both with resp_valid in the 2nd cycle. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- flush at CALC cycle 10 -> state IDLE next cycle; no resp_valid; result keeps its previous value; a following MUL 3*4 returns 12 normally.
- rst low at CALC cycle 5 -> busy/resp_valid/result drop to 0 immediately (asynchronously, without a clock edge); after release, DIV 20/4 -> 5.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Most-negative two's-complement value of width w (w <= 64).
    function automatic logic [63:0] most_neg(input int unsigned w);
        most_neg = 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Execute-stage <-> multiply/divide sequencer handshake bundle.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            resp_valid;
    logic [XLEN-1:0] result;

    modport master (
        output req_valid, funct3, op_a, op_b, flush,
        input  stall, busy, resp_valid, result
    );

    modport slave (
        input  req_valid, funct3, op_a, op_b, flush,
        output stall, busy, resp_valid, result
    );
endinterface

// File: rtl/muldiv_dp.sv
// Iterative datapath: shift-add multiply / restoring divide on magnitudes,
// with sign fix-up applied when the final iteration is committed.
module muldiv_dp
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            finish,
    input  logic            spec_load,
    input  logic            is_div,
    input  logic            neg,
    input  logic            sel_hi,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    input  logic [XLEN-1:0] spec_val,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod;
    logic [XLEN-1:0]   b_q, b_d, result_q, result_d, pick;
    logic [XLEN:0]     sum, diff;

    always_comb begin
        sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, b_q};
        // Trial subtract of the shifted partial remainder; bit XLEN is the borrow.
        diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
        if (is_div) begin
            acc_step = diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                  : {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            acc_step = acc_q[0] ? {sum, acc_q[XLEN-1:1]}
                                : {1'b0, acc_q[2*XLEN-1:1]};
        end

        // finish coincides with the last step, so fix-up works on acc_step.
        prod = neg ? ('0 - acc_step) : acc_step;
        if (is_div) begin
            pick = sel_hi ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
            if (neg) pick = '0 - pick;
        end else begin
            pick = sel_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        end

        acc_d    = acc_q;
        b_d      = b_q;
        result_d = result_q;
        if (load) begin
            acc_d = {{XLEN{1'b0}}, a_mag};
            b_d   = b_mag;
        end else if (step) begin
            acc_d = acc_step;
        end
        if (spec_load)   result_d = spec_val;
        else if (finish) result_d = pick;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M sequencer: holds execute with stall while muldiv_dp iterates,
// then returns the result with a one-cycle resp_valid.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);

    localparam int CNTW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = XLEN'(most_neg(XLEN));

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            neg_q, neg_d;

    logic            sa, sb, signed_a, signed_b, neg_req;
    logic            b_zero, ovf, special;
    logic [XLEN-1:0] a_mag, b_mag, spec_val;
    logic            load, step, finish, spec_load, resp_valid;

    always_comb begin
        sa       = bus.op_a[XLEN-1];
        sb       = bus.op_b[XLEN-1];
        signed_a = 1'b0;
        signed_b = 1'b0;
        neg_req  = 1'b0;
        unique case (bus.funct3)
            F3_MULH:   begin signed_a = 1'b1; signed_b = 1'b1; neg_req = sa ^ sb; end
            F3_MULHSU: begin signed_a = 1'b1; neg_req = sa; end
            F3_DIV:    begin signed_a = 1'b1; signed_b = 1'b1; neg_req = sa ^ sb; end
            F3_REM:    begin signed_a = 1'b1; signed_b = 1'b1; neg_req = sa; end
            F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: neg_req = 1'b0;
            default:   neg_req = 1'b0;
        endcase
        a_mag = (signed_a && sa) ? ('0 - bus.op_a) : bus.op_a;
        b_mag = (signed_b && sb) ? ('0 - bus.op_b) : bus.op_b;

        // funct3[1] distinguishes REM/REMU from DIV/DIVU.
        b_zero   = (bus.op_b == '0);
        ovf      = !bus.funct3[0] && (bus.op_a == MOST_NEG) && (bus.op_b == '1);
        special  = bus.funct3[2] && (b_zero || ovf);
        if (b_zero) spec_val = bus.funct3[1] ? bus.op_a : '1;
        else        spec_val = bus.funct3[1] ? '0 : bus.op_a;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct3_d  = funct3_q;
        neg_d     = neg_q;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        spec_load = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.req_valid && !bus.flush) begin
                    funct3_d = bus.funct3;
                    neg_d    = neg_req;
                    if (special) begin
                        spec_load = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_q == CNTW'(XLEN - 1)) begin
                        finish  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
        end
    end

    muldiv_dp #(.XLEN(XLEN)) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (step),
        .finish    (finish),
        .spec_load (spec_load),
        .is_div    (funct3_q[2]),
        .neg       (neg_q),
        .sel_hi    (funct3_q[2] ? funct3_q[1] : (funct3_q != F3_MUL)),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .spec_val  (spec_val),
        .result    (bus.result)
    );

    assign resp_valid     = (state_q == S_DONE);
    assign bus.resp_valid = resp_valid;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.stall      = bus.req_valid && !resp_valid;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: scoreboard of expected results, popped on resp_valid.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    muldiv_seq_if #(.XLEN(XLEN)) bus();

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
        if (rst && bus.busy && !bus.resp_valid && !bus.flush)
            assert (bus.req_valid) else $error("protocol: req_valid dropped while op in flight");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv;
        logic [63:0] ua, ub, p;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        p   = '0;
        ref_op = '0;
        case (f)
            F3_MUL:    begin p = ua * ub;             ref_op = p[31:0];  end
            F3_MULH:   begin p = sa * sbv;            ref_op = p[63:32]; end
            F3_MULHSU: begin p = sa * longint'(ub);   ref_op = p[63:32]; end
            F3_MULHU:  begin p = ua * ub;             ref_op = p[63:32]; end
            F3_DIV: begin
                if (b == 0) ref_op = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_op = a;
                else begin p = sa / sbv; ref_op = p[31:0]; end
            end
            F3_REM: begin
                if (b == 0) ref_op = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_op = 32'h0;
                else begin p = sa % sbv; ref_op = p[31:0]; end
            end
            F3_DIVU: ref_op = (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: ref_op = (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drives one request (entered just after a negedge), waits for resp_valid,
    // checks latency/stall/result, and leaves the request held for one more cycle.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name);
        int stall_cnt;
        int cyc;
        bit got;
        logic [31:0] e;
        stall_cnt = 0;
        cyc = 0;
        got = 0;
        exp_q.push_back(exp);
        bus.req_valid = 1'b1;
        bus.funct3    = f3;
        bus.op_a      = a;
        bus.op_b      = b;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (bus.resp_valid) begin
                cyc = c;
                got = 1;
                break;
            end
            if (bus.stall) stall_cnt++;
            @(negedge clk);
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s timeout: no resp_valid within 40 cycles", name);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.result !== e) begin
                errors++;
                $display("FAIL %s result: got %h expected %h", name, bus.result, e);
            end
            checks++;
            if (cyc !== lat) begin
                errors++;
                $display("FAIL %s latency: resp in cycle %0d expected %0d", name, cyc, lat);
            end
            checks++;
            if (bus.stall !== 1'b0) begin
                errors++;
                $display("FAIL %s stall_in_resp: got %b expected 0", name, bus.stall);
            end
        end
        checks++;
        if (stall_cnt !== lat - 1) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, stall_cnt, lat - 1);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s resp_pulse: resp_valid got %b expected 0", name, bus.resp_valid);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.funct3    = 3'b000;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.flush     = 1'b0;
        rst           = 1'b0;
        #2;
        checks++;
        if ({bus.busy, bus.resp_valid, bus.stall} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: busy/resp/stall got %b expected 000", {bus.busy, bus.resp_valid, bus.stall});
        end
        checks++;
        if (bus.result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 00000000", bus.result);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle: busy/resp got %b expected 00", {bus.busy, bus.resp_valid});
        end
    endtask

    task automatic test_mul();
        do_op(F3_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7_m3");
        do_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min_min");
        do_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_ff_ff");
        do_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu_ff_ff");
    endtask

    task automatic test_div();
        do_op(F3_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
        do_op(F3_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
        do_op(F3_DIVU, 32'd100,       32'd7, 32'd14,        34, "divu_100_7");
        do_op(F3_REMU, 32'd100,       32'd7, 32'd2,         34, "remu_100_7");
    endtask

    task automatic test_special();
        do_op(F3_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 2, "divu_by0");
        do_op(F3_REMU, 32'd5,         32'd0,         32'd5,         2, "remu_by0");
        do_op(F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf");
        do_op(F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         2, "rem_ovf");
        do_op(F3_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 2, "div_by0");
    endtask

    task automatic test_flush();
        do_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 34, "flush_pre");
        bus.req_valid = 1'b1;
        bus.funct3    = F3_MUL;
        bus.op_a      = 32'h1234_5678;
        bus.op_b      = 32'd9;
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_busy_before: got %b expected 1", bus.busy);
        end
        @(negedge clk);
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.resp_valid} !== 2'b00) begin
            errors++;
            $display("FAIL flush_idle: busy/resp got %b expected 00", {bus.busy, bus.resp_valid});
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.resp_valid !== 1'b0 || bus.result !== 32'd14) begin
                errors++;
                $display("FAIL flush_hold: resp %b result %h expected resp 0 result 0000000e", bus.resp_valid, bus.result);
            end
            @(negedge clk);
            #1;
        end
        do_op(F3_MUL, 32'd3, 32'd4, 32'd12, 34, "mul_after_flush");
    endtask

    task automatic test_async_reset();
        bus.req_valid = 1'b1;
        bus.funct3    = F3_DIVU;
        bus.op_a      = 32'h0001_0000;
        bus.op_b      = 32'd3;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.resp_valid} !== 2'b00 || bus.result !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: busy %b resp %b result %h expected 0 0 00000000", bus.busy, bus.resp_valid, bus.result);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_op(F3_DIV, 32'd20, 32'd4, 32'd5, 34, "div_after_reset");
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f;
        logic [31:0] a, b;
        bit          spc;
        for (int i = 0; i < 12; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = b >> $urandom_range(0, 31);
                default: ;
            endcase
            spc = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
            do_op(f, a, b, ref_op(f, a, b), spc ? 2 : 34, $sformatf("b2b_%0d_f%0d", i, f));
        end
        bus.req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_async_reset();
        test_back_to_back();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
